// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with registered result/zero flag and a one-cycle
// done_o pulse per accepted operation. Shifts (sll/sra) by a nonzero amount
// run on a serial one-bit-per-cycle shifter. Defining the macro
// SEQ_ALU_BARREL_SHIFT_EN makes them single-cycle with a barrel shifter;
// in that build the SHIFT state is not built and busy_o is tied to 0.
//
// Ports:
//   clk_i      - clock, rising edge
//   rst_i      - asynchronous active-high reset
//   start_i    - request; captured only while idle
//   ALU_Ctrl_i - 4-bit operation code
//   src1_i     - operand A
//   src2_i     - operand B / shift amount (low log2(DATA_W) bits)
//   result_o   - registered result
//   zero_o     - registered zero / branch-taken flag
//   busy_o     - high while a serial shift is running
//   done_o     - one-cycle pulse marking new result_o/zero_o
module seq_alu #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [3:0]        ALU_Ctrl_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int SH_W = $clog2(DATA_W);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_BNE = 4'b1110;

  logic [SH_W-1:0]   sh_amt;
  logic [DATA_W-1:0] alu_res;
  logic              alu_zero;

  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic              done_q, done_d;

  assign sh_amt = src2_i[SH_W-1:0];

  // Single-cycle datapath on the live inputs; its value is registered at the
  // accepting edge, which is what captures the operands for these ops.
  always_comb begin
    alu_res = '0;
    case (ALU_Ctrl_i)
      OP_ADD:         alu_res = src1_i + src2_i;
      OP_SUB, OP_BNE: alu_res = src1_i - src2_i;
      OP_SLT:         alu_res = {{(DATA_W-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      OP_XOR:         alu_res = src1_i ^ src2_i;
      OP_OR:          alu_res = src1_i | src2_i;
      OP_AND:         alu_res = src1_i & src2_i;
`ifdef SEQ_ALU_BARREL_SHIFT_EN
      OP_SLL:         alu_res = src1_i << sh_amt;
      OP_SRA:         alu_res = $signed(src1_i) >>> sh_amt;
`else
      // Only used for a zero shift amount; nonzero amounts go through SHIFT.
      OP_SLL, OP_SRA: alu_res = src1_i;
`endif
      default:        alu_res = '0;
    endcase
    // bne reports "branch taken" (operands differ) on zero_o.
    alu_zero = (ALU_Ctrl_i == OP_BNE) ? (alu_res != '0) : (alu_res == '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

`ifdef SEQ_ALU_BARREL_SHIFT_EN

  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    if (start_i) begin
      result_d = alu_res;
      zero_d   = alu_zero;
      done_d   = 1'b1;
    end
  end

  assign busy_o = 1'b0;

`else

  // state | meaning
  // IDLE  | waiting for start_i; non-shift and zero-amount shifts finish here
  // SHIFT | serial shift running, one bit per cycle, busy_o high
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [SH_W-1:0]   cnt_q, cnt_d;
  logic              sra_q, sra_d;
  logic [DATA_W-1:0] shifted;
  logic              is_shift;

  assign is_shift = (ALU_Ctrl_i == OP_SLL) || (ALU_Ctrl_i == OP_SRA);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      sra_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      sra_q   <= sra_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    sra_d    = sra_q;
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    shifted  = sra_q ? {shreg_q[DATA_W-1], shreg_q[DATA_W-1:1]}
                     : {shreg_q[DATA_W-2:0], 1'b0};
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (is_shift && (sh_amt != '0)) begin
            shreg_d = src1_i;
            cnt_d   = sh_amt;
            sra_d   = (ALU_Ctrl_i == OP_SRA);
            state_d = SHIFT;
          end else begin
            result_d = alu_res;
            zero_d   = alu_zero;
            done_d   = 1'b1;
          end
        end
      end
      SHIFT: begin
        shreg_d = shifted;
        cnt_d   = cnt_q - SH_W'(1);
        // Last bit: publish directly so result_o never shows partial shifts.
        if (cnt_q == SH_W'(1)) begin
          result_d = shifted;
          zero_d   = (shifted == '0);
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q == SHIFT);

`endif

  assign result_o = result_q;
  assign zero_o   = zero_q;
  assign done_o   = done_q;

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width; power of two, 8 or greater; shift amount = low log2(DATA_W) bits of src2_i.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port start_i  input  1  request; samples operation and operands when accepted.
REQ-005 SHALL have port ALU_Ctrl_i  input  4  operation code from the ALU control stage.
REQ-006 SHALL have port src1_i  input  DATA_W  operand A.
REQ-007 SHALL have port src2_i  input  DATA_W  operand B / shift amount.
REQ-008 SHALL have port result_o  output  DATA_W  registered result.
REQ-009 SHALL have port zero_o  output  1  registered branch/zero flag.
REQ-010 SHALL have port busy_o  output  1  high while a multi-cycle shift is in progress.
REQ-011 SHALL have port done_o  output  1  one-cycle pulse marking a new result_o/zero_o.

Function
REQ-012 SHALL decode ALU_Ctrl_i: 0010 add; 0110 sub; 1110 sub (bne); 0100 sll; 0111 slt (signed); 0011 xor; 0001 or; 0000 and; 0101 sra (arithmetic); any other code -> result 0.
REQ-013 SHALL use two states: IDLE (busy_o=0) and SHIFT (busy_o=1).
REQ-014 SHALL accept start_i only in IDLE; start_i in SHIFT is ignored, not queued.
REQ-015 SHALL capture ALU_Ctrl_i, src1_i and src2_i at the accepting edge; later input changes do not affect that operation.
REQ-016 Non-shift op, or shift with amount 0: result_o, zero_o and done_o=1 SHALL be registered at the accepting edge, i.e. visible in the cycle after start_i; state stays IDLE.
REQ-017 Shift with amount k>0: SHALL enter SHIFT and shift the captured operand one bit per cycle for k cycles; sll fills with 0, sra fills with the sign bit.
REQ-018 A k>0 shift SHALL deliver done_o in cycle k+1, where cycle 0 is the start_i cycle; the state returns to IDLE on that same edge.
REQ-019 SHALL accept a new start_i in the cycle done_o is high, giving one result per cycle for back-to-back non-shift ops.
REQ-020 done_o SHALL be high for exactly one cycle per accepted operation.
REQ-021 result_o and zero_o SHALL hold their values until the next done_o.
REQ-022 zero_o SHALL be (result==0) for all codes except 1110, where zero_o = (result!=0), i.e. branch taken.
REQ-023 add/sub SHALL wrap modulo 2^DATA_W with no overflow flag; slt SHALL output 1 or 0, zero-extended.
REQ-024 While in SHIFT, result_o and zero_o SHALL NOT show intermediate shift values.

Reset
REQ-025 rst_i high SHALL immediately force IDLE, result_o=0, zero_o=0, busy_o=0, done_o=0, and clear the shift counter and captured operands.
REQ-026 Reset during SHIFT SHALL abandon the operation with no done_o; start_i is first accepted on the first rising edge after rst_i deasserts.

Configuration
REQ-027 Macro SEQ_ALU_BARREL_SHIFT_EN defined: sll and sra SHALL complete in one cycle (combinational barrel shifter), the SHIFT state SHALL NOT exist, and busy_o SHALL be tied to 0.
REQ-028 Macro undefined: the serial shifter of REQ-017/REQ-018 SHALL be used; all other behaviour is identical in both builds.

Verification
REQ-029 Reset test: assert rst_i asynchronously mid-cycle -> all outputs 0 at once, before any clock edge.
REQ-030 Back-to-back ops: add 5+7, then sub 3-3, then bne 4,9 on consecutive cycles -> done_o high three consecutive cycles; result/zero = 12/0, 0/1, 0xFFFFFFFB/1.
REQ-031 slt/sra sign: slt 0xFFFFFFFF,1 -> result 1; sra 0x80000000 by 4 -> result 0xF8000000, done_o in cycle 5 (serial build) or cycle 1 (barrel build).
REQ-032 Shift busy rule: sll 1 by 31 with start_i held high throughout -> busy_o high cycles 1-31, result 0x80000000 in cycle 32, extra starts during busy ignored, next op accepted in cycle 32.
REQ-033 Edge codes: sll by 0 -> done in cycle 1, result = src1; ALU_Ctrl_i=1111 -> result 0, zero_o 1.
REQ-034 Reset mid-shift: sra by 20, rst_i pulsed in cycle 10 -> no done_o, outputs 0, next add accepted normally.
